// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared widths, state encoding and constants for the SRAM port controller
package sram_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 11;
    localparam int NUM_WMASKS_DEF = 2;
    localparam int FIFO_DEPTH     = 2;

    // Bit value replicated across the data word during the zero-fill sequence
    localparam logic CLR_FILL = 1'b0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - 2-entry in-order read response buffer with occupancy count
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_rdata,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Entries are cleared on reset so the head reads as zero afterwards
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - request/response front end and zero-fill sequencer for a single RW SRAM port
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_WMASKS = NUM_WMASKS_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [NUM_WMASKS-1:0] i_req_wmask,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    input  logic                  i_clr_start,
    output logic                  o_busy,
    output logic                  o_clr_done,
    output logic                  o_sram_csb,
    output logic                  o_sram_web,
    output logic [NUM_WMASKS-1:0] o_sram_wmask,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_din,
    input  logic [DATA_WIDTH-1:0] i_sram_dout
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;
    logic                  r_rd_pend;
    logic                  r_clr_done;
    logic                  w_clr_done_nxt;
    logic                  w_fifo_valid;
    logic [1:0]            w_fifo_count;
    logic                  w_pop;
    logic [2:0]            w_occupancy;
    logic                  w_req_ready;
    logic                  w_accept;

    // Credit: buffered entries plus the read still in the SRAM, less the one leaving now
    assign w_pop       = w_fifo_valid && i_rsp_ready;
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_req_ready = i_rst_n && (r_state == ST_RUN) && !i_clr_start
                         && (w_occupancy < 3'(FIFO_DEPTH));
    assign w_accept    = i_req_valid && w_req_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_done_nxt = 1'b0;
        o_sram_csb     = 1'b1;
        o_sram_web     = 1'b1;
        o_sram_wmask   = '0;
        o_sram_addr    = '0;
        o_sram_din     = '0;
        case (r_state)
            ST_RUN: begin
                if (i_clr_start && !r_rd_pend) begin
                    w_state_nxt = ST_CLEAR;
                end
                if (w_accept) begin
                    o_sram_csb   = 1'b0;
                    o_sram_web   = !i_req_we;
                    o_sram_wmask = i_req_we ? i_req_wmask : '0;
                    o_sram_addr  = i_req_addr;
                    o_sram_din   = i_req_wdata;
                end
            end
            ST_CLEAR: begin
                o_sram_csb     = 1'b0;
                o_sram_web     = 1'b0;
                o_sram_wmask   = '1;
                o_sram_addr    = r_clr_addr;
                o_sram_din     = {DATA_WIDTH{CLR_FILL}};
                w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
                if (r_clr_addr == '1) begin
                    w_state_nxt    = ST_RUN;
                    w_clr_addr_nxt = '0;
                    w_clr_done_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_clr_addr <= '0;
            r_rd_pend  <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_rd_pend  <= w_accept && !i_req_we;
            r_clr_done <= w_clr_done_nxt;
        end
    end

    // SRAM dout is valid one cycle after the read was sampled, so capture it then
    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_rd_pend),
        .i_wdata (i_sram_dout),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_rdata (o_rsp_rdata),
        .o_count (w_fifo_count)
    );

    assign o_req_ready = w_req_ready;
    assign o_rsp_valid = w_fifo_valid;
    assign o_busy      = (r_state == ST_CLEAR);
    assign o_clr_done  = r_clr_done;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb/tb_sram_port_ctrl.sv - directed self-checking bench for sram_port_ctrl with a behavioural SRAM
module tb_sram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_wmask = 2'b00;
    logic [10:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic        clr_start = 1'b0;
    logic        busy;
    logic        clr_done;
    logic        sram_csb;
    logic        sram_web;
    logic [1:0]  sram_wmask;
    logic [10:0] sram_addr;
    logic [15:0] sram_din;
    logic [15:0] sram_dout = '0;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    logic [15:0] mem [2048];
    logic        rd_q = 1'b0;
    logic [10:0] ra_q = '0;
    logic [15:0] rsp_q [$];
    int          cyc_q [$];

    sram_port_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_wmask  (req_wmask),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_rdata  (rsp_rdata),
        .i_clr_start  (clr_start),
        .o_busy       (busy),
        .o_clr_done   (clr_done),
        .o_sram_csb   (sram_csb),
        .o_sram_web   (sram_web),
        .o_sram_wmask (sram_wmask),
        .o_sram_addr  (sram_addr),
        .o_sram_din   (sram_din),
        .i_sram_dout  (sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port SRAM: inputs sampled at posedge, read data appears after the following negedge
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h5A5A;
    end

    always @(posedge clk) begin
        rd_q <= 1'b0;
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 2; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end else begin
                rd_q <= 1'b1;
                ra_q <= sram_addr;
            end
        end
    end

    always @(negedge clk) if (rd_q) sram_dout <= mem[ra_q];

    always begin
        @(negedge clk);
        #3;
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_q.push_back(rsp_rdata);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_req(input logic we, input logic [10:0] addr, input logic [15:0] data,
                          input logic [1:0] mask);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wmask = mask;
        #1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("req_accept_in_time", 32'(n < 20), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic get_rsp(input string tag, output logic [15:0] d);
        int n;
        n = 0;
        while (rsp_q.size() == 0 && n < 30) begin
            @(negedge clk);
            #4;
            n++;
        end
        check(tag, 32'(rsp_q.size() != 0), 32'd1);
        d = 16'hDEAD;
        if (rsp_q.size() != 0) begin
            d = rsp_q.pop_front();
            void'(cyc_q.pop_front());
        end
    endtask

    task automatic wait_rsp_count(input int want);
        int n;
        n = 0;
        while (rsp_q.size() < want && n < 40) begin
            @(negedge clk);
            #4;
            n++;
        end
        repeat (3) @(negedge clk);
        #4;
    endtask

    initial begin
        logic [15:0] d;
        int acc, n, busy_cnt, done_cnt, bad_ready, accepted, nz, errs;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
        check("rst_busy_done", {busy, clr_done}, 32'd0);
        check("rst_sram_ctl", {sram_csb, sram_web, sram_wmask}, 32'b1100);
        check("rst_sram_addr_din", {sram_addr, sram_din}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Test 1: write then read, two-cycle read latency
        do_req(1'b1, 11'd5, 16'hBEEF, 2'b11);
        rsp_q.delete(); cyc_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd5;
        #1;
        check("t1_ready", 32'(req_ready), 32'd1);
        check("t1_sram_read_drive", {sram_csb, sram_web, sram_wmask, 5'd0, sram_addr},
              {1'b0, 1'b1, 2'b00, 5'd0, 11'd5});
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("t1_not_valid_k1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("t1_valid_k2", 32'(rsp_valid), 32'd1);
        check("t1_rdata", 32'(rsp_rdata), 32'hBEEF);
        wait_rsp_count(1);
        rsp_q.delete(); cyc_q.delete();

        // Test 2: byte-masked write merges with existing word
        do_req(1'b1, 11'd7, 16'h1234, 2'b11);
        do_req(1'b1, 11'd7, 16'hAB00, 2'b10);
        do_req(1'b0, 11'd7, 16'h0000, 2'b00);
        get_rsp("t2_rsp_arrives", d);
        check("t2_masked_merge", 32'(d), 32'hAB34);

        // Test 3: eight back-to-back reads at full rate
        for (int i = 0; i < 8; i++) do_req(1'b1, 11'(i), 16'hA000 + 16'(i), 2'b11);
        rsp_q.delete(); cyc_q.delete();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_addr = 11'(i);
            #1;
            if (!req_ready) n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("t3_no_stall", 32'(n), 32'd0);
        wait_rsp_count(8);
        check("t3_rsp_count", 32'(rsp_q.size()), 32'd8);
        errs = 0;
        for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
            check("t3_rdata", 32'(rsp_q[i]), 32'hA000 + 32'(i));
            if (cyc_q[i] - cyc_q[0] != i) errs++;
        end
        check("t3_consecutive", 32'(errs), 32'd0);
        rsp_q.delete(); cyc_q.delete();

        // Test 4: backpressure limits outstanding reads to two
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_addr = 11'(acc);
            #1;
            if (req_ready) acc++;
        end
        check("t4_accepts_before_stall", 32'(acc), 32'd2);
        check("t4_ready_low", 32'(req_ready), 32'd0);
        check("t4_head", {15'd0, rsp_valid, rsp_rdata}, {15'd0, 1'b1, 16'hA000});
        @(negedge clk);
        #1;
        check("t4_head_hold", 32'(rsp_rdata), 32'hA000);
        n = 0;
        while (acc < 4 && n < 20) begin
            @(negedge clk);
            rsp_ready = 1'b1; req_addr = 11'(acc);
            #1;
            if (req_ready) acc++;
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("t4_all_accepted", 32'(acc), 32'd4);
        wait_rsp_count(4);
        check("t4_rsp_count", 32'(rsp_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < rsp_q.size(); i++)
            check("t4_rdata_order", 32'(rsp_q[i]), 32'hA000 + 32'(i));
        rsp_q.delete(); cyc_q.delete();

        // Test 5: zero-fill wins over a simultaneous request
        do_req(1'b1, 11'd0, 16'hFFFF, 2'b11);
        do_req(1'b1, 11'd1, 16'hFFFF, 2'b11);
        do_req(1'b1, 11'd1024, 16'hFFFF, 2'b11);
        do_req(1'b1, 11'd2047, 16'hFFFF, 2'b11);
        @(negedge clk);
        clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd1024;
        #1;
        check("t5_start_blocks_req", {30'd0, req_ready, sram_csb}, 32'b01);
        busy_cnt = 0; done_cnt = 0; bad_ready = 0; accepted = 0;
        for (int c = 0; c < 2100 && accepted == 0; c++) begin
            @(negedge clk);
            clr_start = 1'b0;
            #1;
            if (busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (busy && req_ready) bad_ready++;
            if (req_ready) accepted = 1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("t5_busy_cycles", 32'(busy_cnt), 32'd2048);
        check("t5_done_pulses", 32'(done_cnt), 32'd1);
        check("t5_no_accept_while_busy", 32'(bad_ready), 32'd0);
        check("t5_req_accepted_after", 32'(accepted), 32'd1);
        check("t5_done_single_cycle", 32'(clr_done), 32'd0);
        get_rsp("t5_rsp_arrives", d);
        check("t5_addr1024_zero", 32'(d), 32'd0);
        do_req(1'b0, 11'd0, 16'd0, 2'b00);
        get_rsp("t5_rsp0_arrives", d);
        check("t5_addr0_zero", 32'(d), 32'd0);
        do_req(1'b0, 11'd2047, 16'd0, 2'b00);
        get_rsp("t5_rsp2047_arrives", d);
        check("t5_addr2047_zero", 32'(d), 32'd0);
        nz = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== 16'h0000) nz++;
        check("t5_array_zeroed", 32'(nz), 32'd0);

        // Test 6a: reset in the middle of a clear
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check("t6_clear_running", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6a_ctl_reset", {27'd0, busy, clr_done, req_ready, rsp_valid, sram_csb}, 32'b00001);
        check("t6a_sram_reset", {sram_web, sram_wmask, sram_addr, sram_din[15:0]}, 32'h8000_0000 >> 2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (clr_done || busy) n++;
        end
        check("t6a_no_done_after_abort", 32'(n), 32'd0);

        // Test 6b: reset with a read still pending in the SRAM
        rsp_ready = 1'b0;
        rsp_q.delete(); cyc_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd3;
        #1;
        check("t6b_read_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6b_rsp_reset", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
        check("t6b_ready_in_reset", 32'(req_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) n++;
        end
        check("t6b_no_stale_rsp", 32'(n + rsp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Initiator-side controller for the team's OpenRAM-style single RW port (active-low chip select and write enable, byte write mask, inputs sampled at posedge, read data updated after negedge).
- Converts a valid/ready request stream into SRAM port cycles and returns read data on a backpressurable response stream through a 2-entry buffer.
- Provides a hardware clear sequencer that zero-fills the whole array.
- Sits between the CPU/peripheral bus adapters and each SRAM macro instance.

Parameters:
- DATA_WIDTH, 16: word width in bits.
- ADDR_WIDTH, 11: word address width; depth = 2**ADDR_WIDTH.
- NUM_WMASKS, 2: byte-lane mask width; DATA_WIDTH = 8*NUM_WMASKS.

Ports:
- clk  in  1  single clock; also drives the SRAM clk0.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- req_we  in  1  1 = write, 0 = read.
- req_wmask  in  NUM_WMASKS  byte enables (writes only).
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_WIDTH  read data, in request order.
- clr_start  in  1  pulse: begin zero-fill.
- busy  out  1  high while clear is running.
- clr_done  out  1  one-cycle pulse after the last clear write.
- sram_csb  out  1  to SRAM csb0.
- sram_web  out  1  to SRAM web0.
- sram_wmask  out  NUM_WMASKS  to SRAM wmask0.
- sram_addr  out  ADDR_WIDTH  to SRAM addr0.
- sram_din  out  DATA_WIDTH  to SRAM din0.
- sram_dout  in  DATA_WIDTH  from SRAM dout0.

Behaviour:
- **States**
  - RUN: the reset state.
  - CLEAR: entered when clr_start=1 in RUN with rd_pend=0. Otherwise clr_start is ignored.
- **SRAM drive** (combinational)
  - Request accepted in cycle k: sram_csb=0, sram_web=!req_we, sram_wmask=req_we ? req_wmask : 0, sram_addr=req_addr, sram_din=req_wdata. The SRAM samples these at the posedge ending cycle k.
  - Idle: sram_csb=1, sram_web=1, sram_wmask=0.
- **Read timing**
  - rd_pend is set at the accepting edge.
  - sram_dout is captured into the FIFO at the following edge.
  - rsp_valid is high from cycle k+2 onward. Minimum latency is 2 cycles; there is no combinational path from sram_dout to rsp_rdata.
- **Writes** produce no response. Write latency is invisible to the requester.
- **req_ready**
  - req_ready = (state==RUN) && !clr_start && (fifo_count + rd_pend - pop < 2), where pop = rsp_valid && rsp_ready.
  - req_ready does not depend on req_valid.
  - Sustains 1 read/cycle when rsp_ready=1.
- **FIFO**
  - 2 entries, strict order.
  - rsp_rdata is the head entry. It holds stable while rsp_valid && !rsp_ready.
  - Simultaneous push and pop are allowed.
  - Overflow is impossible by the credit rule.
- **CLEAR**
  - Counter clr_addr starts at 0 and increments each cycle.
  - Each cycle drives sram_csb=0, sram_web=0, sram_wmask=all ones, sram_addr=clr_addr, sram_din=0.
  - After address 2**ADDR_WIDTH-1 is written: clr_done=1 for one cycle, return to RUN, counter reset to 0.
  - Total busy time is exactly 2**ADDR_WIDTH cycles.
  - FIFO contents survive the clear and can drain during it.
- **Simultaneous clr_start and req_valid**: clear wins; the request is not accepted that cycle.
- **Reset values**: req_ready=0 while rst_n=0, rsp_valid=0, rsp_rdata=0, busy=0, clr_done=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
- **Reset mid-operation**:
  - FIFO is flushed and the pending read is dropped.
  - A clear in progress is aborted, with no clr_done.
  - SRAM contents are undefined for the partially cleared range.

Decomposition:
- Package sram_ctrl_pkg holds:
  - width defaults;
  - state encoding RUN/CLEAR;
  - CLR_FILL constant (0);
  - FIFO_DEPTH=2.
- Sub-module sram_rsp_fifo: 2-entry synchronous FIFO with count output, same clk/rst_n.

Test Plan:
1. Write 0xBEEF to addr 5 with mask 2'b11, then read addr 5 with rsp_ready=1 -> rsp_valid exactly 2 cycles after read accept, rsp_rdata=0xBEEF.
2. Write 0x1234 to addr 7, then write 0xAB00 with mask 2'b10, then read -> 0xAB34.
3. Back-to-back reads of addrs 0..7 with rsp_ready=1 -> req_ready stays 1 and 8 responses arrive on 8 consecutive cycles, in order.
4. Issue 4 reads with rsp_ready=0 -> req_ready drops after 2 accepts, rsp_rdata holds the first value; raise rsp_ready -> remaining reads accepted, 4 ordered responses, none lost or duplicated.
5. clr_start asserted with req_valid=1 after filling addrs with 0xFFFF -> busy=1 for 2048 cycles, clr_done one pulse, request accepted only after; reads of addrs 0, 1024, 2047 return 0.
6. Assert rst_n=0 mid-clear and with 1 pending read -> all outputs go to reset values asynchronously, no clr_done, no stale rsp_valid after release.
